config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 Parameter WORD_W, default 384, SHALL set the width of one configuration frame word.
REQ-002 Parameter NUM_FRAMES, default 267, SHALL set the number of frames and the width of configs_en.
REQ-003 Parameter SETTLE_CYCLES, default 10, SHALL set each post-load delay in clock cycles; legal range is 1 or more.
REQ-004 Port clock, input, 1 bit, SHALL be the single clock; every flop SHALL be clocked on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset: asynchronous, active-high.
REQ-006 Port start, input, 1 bit, SHALL request a load when sampled high.
REQ-007 Ports cfg_valid (input, 1 bit), cfg_ready (output, 1 bit) and cfg_data (input, WORD_W bits) SHALL form the frame-word stream; a word is accepted in a cycle where cfg_valid and cfg_ready are both high.
REQ-008 Port configs_in, output, WORD_W bits, SHALL carry the frame data to the fabric.
REQ-009 Port configs_en, output, NUM_FRAMES bits, SHALL carry the one-hot frame write strobe.
REQ-010 Port ff_en, output, 1 bit, SHALL release the fabric flip-flops.
REQ-011 Port rdy, output, 1 bit, SHALL indicate the fabric is configured and running.
REQ-012 Port busy, output, 1 bit, SHALL be high in every state except IDLE, DONE and ERROR.
REQ-013 Port frame_cnt, output, clog2(NUM_FRAMES+1) bits, SHALL give the number of frames written so far.
REQ-014 Port err, output, 1 bit, SHALL flag a checksum failure.

Function
REQ-015 The state machine SHALL have the states IDLE, LOAD, WRITE, SETTLE_FF, SETTLE_RDY, DONE and ERROR.
REQ-016 IDLE: start=1 SHALL move to LOAD and clear frame_cnt.
REQ-017 LOAD: cfg_ready SHALL be 1; on acceptance, configs_in SHALL take cfg_data at that edge and the state SHALL move to WRITE.
REQ-018 WRITE: configs_en SHALL equal 1 shifted left by frame_cnt for exactly one cycle.
REQ-019 In WRITE, configs_in SHALL hold stable and cfg_ready SHALL be 0; maximum throughput is one word per 2 cycles.
REQ-020 Leaving WRITE, frame_cnt SHALL increment; if it now equals NUM_FRAMES the state SHALL move to SETTLE_FF, otherwise back to LOAD.
REQ-021 In LOAD with cfg_valid=0, the machine SHALL wait indefinitely with no timeout.
REQ-022 Outside WRITE, configs_en SHALL be all zeros.
REQ-023 SETTLE_FF SHALL last exactly SETTLE_CYCLES cycles, then ff_en SHALL go to 1 and the state SHALL move to SETTLE_RDY.
REQ-024 SETTLE_RDY SHALL last exactly SETTLE_CYCLES cycles, then rdy SHALL go to 1 and the state SHALL move to DONE.
REQ-025 DONE SHALL hold ff_en=1 and rdy=1.
REQ-026 start=1 in DONE or ERROR (reconfiguration) SHALL clear ff_en, rdy, err and frame_cnt in the same edge and move to LOAD.
REQ-027 start in LOAD, WRITE, SETTLE_FF or SETTLE_RDY SHALL be ignored.
REQ-028 cfg_valid outside LOAD SHALL be ignored and no word consumed.
REQ-029 frame_cnt SHALL never exceed NUM_FRAMES and SHALL not wrap.

Reset
REQ-030 While rst=1, the state SHALL be IDLE and all outputs SHALL be 0: configs_in, configs_en, ff_en, rdy, busy, frame_cnt, err and cfg_ready.
REQ-031 Reset mid-load SHALL abandon the load; a new start SHALL restart from frame 0.

Configuration
REQ-032 With macro CONFIG_LOADER_CHECKSUM_EN defined, a running XOR of all accepted frame words SHALL be kept, and after the last WRITE the machine SHALL enter a CHECK state with cfg_ready=1.
REQ-033 In CHECK, the next accepted word SHALL be compared with the running XOR: equal moves to SETTLE_FF; unequal moves to ERROR with err=1 and ff_en=0.
REQ-034 Without CONFIG_LOADER_CHECKSUM_EN, the CHECK state and the checksum register SHALL not exist, err SHALL be tied to 0, and ERROR SHALL be unreachable.

Structure
REQ-035 Package config_loader_pkg SHALL hold the state enum and the default parameter constants.
REQ-036 Sub-module config_settle_timer SHALL implement the loadable down-counter of SETTLE_CYCLES with a done pulse, reused for both settle phases.

Verification (WORD_W=8, NUM_FRAMES=4, SETTLE_CYCLES=3)
REQ-037 Reset, start, words 0x11/0x22/0x33/0x44 with valid held high -> configs_en strobes 0001, 0010, 0100, 1000 with configs_in equal to the matching word; frame_cnt=4; ff_en 3 cycles after the last strobe; rdy 3 cycles after ff_en.
REQ-038 cfg_valid held low for 5 cycles between words 2 and 3 -> no strobe during the gap, frame_cnt stays 2, ordering intact.
REQ-039 rst asserted after 2 frames, then start with 4 new words -> first strobe is 0001, full load completes.
REQ-040 start pulsed in WRITE and in SETTLE_FF -> ignored; start in DONE -> ff_en and rdy drop next edge, reload completes.
REQ-041 CHECKSUM_EN, words 0x11/0x22/0x33/0x44 with trailer 0x44 -> DONE; with trailer 0x45 -> err=1, ff_en=0, rdy=0.

Source files
------------

// File: rtl/config_loader_pkg.sv
// Shared state encoding and default sizing for the configuration loader.
// CONFIG_LOADER_CHECKSUM_EN adds the trailer-checksum CHECK state.
package config_loader_pkg;

  localparam int unsigned DefWordW        = 384;
  localparam int unsigned DefNumFrames    = 267;
  localparam int unsigned DefSettleCycles = 10;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StSettleFf,
    StSettleRdy,
    StDone,
    StError
`ifdef CONFIG_LOADER_CHECKSUM_EN
    , StCheck
`endif
  } state_e;

endpackage

// File: rtl/config_settle_timer.sv
// Loadable down-counter: after a load, done pulses in the CYCLES-th cycle.
// Shared by both settle phases of the configuration loader.
module config_settle_timer
  import config_loader_pkg::*;
#(
  parameter int unsigned CYCLES = DefSettleCycles
) (
  input  logic clock,
  input  logic rst,
  input  logic load,
  output logic done
);

  localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            active_q, active_d;

  always_comb begin
    cnt_d    = cnt_q;
    active_d = active_q;
    if (load) begin
      cnt_d    = LoadVal;
      active_d = 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CntW'(1);
      end
    end
  end

  assign done = active_q && (cnt_q == '0);

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      active_q <= active_d;
    end
  end

endmodule

// File: rtl/config_loader.sv
// Streams NUM_FRAMES frame words into the fabric, then releases flops and ready.
// Optional feature macro: CONFIG_LOADER_CHECKSUM_EN (XOR trailer check).
module config_loader
  import config_loader_pkg::*;
#(
  parameter int unsigned WORD_W        = DefWordW,
  parameter int unsigned NUM_FRAMES    = DefNumFrames,
  parameter int unsigned SETTLE_CYCLES = DefSettleCycles
) (
  input  logic                              clock,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              cfg_valid,
  output logic                              cfg_ready,
  input  logic [WORD_W-1:0]                 cfg_data,
  output logic [WORD_W-1:0]                 configs_in,
  output logic [NUM_FRAMES-1:0]             configs_en,
  output logic                              ff_en,
  output logic                              rdy,
  output logic                              busy,
  output logic [$clog2(NUM_FRAMES+1)-1:0]   frame_cnt,
  output logic                              err
);

  localparam int unsigned CntW = $clog2(NUM_FRAMES + 1);
  localparam logic [CntW-1:0]       FrameTotal = CntW'(NUM_FRAMES);
  localparam logic [NUM_FRAMES-1:0] EnOne      = NUM_FRAMES'(1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   frame_cnt_q, frame_cnt_d, frame_cnt_inc;
  logic [WORD_W-1:0] configs_in_q, configs_in_d;
  logic              ff_en_q, ff_en_d;
  logic              rdy_q, rdy_d;
  logic              tmr_load, tmr_done;

`ifdef CONFIG_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] csum_q, csum_d;
  logic              err_q, err_d;
`endif

  config_settle_timer #(
    .CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clock (clock),
    .rst   (rst),
    .load  (tmr_load),
    .done  (tmr_done)
  );

  assign frame_cnt_inc = frame_cnt_q + CntW'(1);

  always_comb begin
    state_d      = state_q;
    frame_cnt_d  = frame_cnt_q;
    configs_in_d = configs_in_q;
    ff_en_d      = ff_en_q;
    rdy_d        = rdy_q;
    tmr_load     = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    csum_d       = csum_q;
    err_d        = err_q;
`endif
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StLoad;
          frame_cnt_d = '0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          csum_d      = '0;
`endif
        end
      end
      StLoad: begin
        if (cfg_valid) begin
          configs_in_d = cfg_data;
          state_d      = StWrite;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          csum_d       = csum_q ^ cfg_data;
`endif
        end
      end
      StWrite: begin
        frame_cnt_d = frame_cnt_inc;
        if (frame_cnt_inc == FrameTotal) begin
`ifdef CONFIG_LOADER_CHECKSUM_EN
          state_d  = StCheck;
`else
          state_d  = StSettleFf;
          tmr_load = 1'b1;
`endif
        end else begin
          state_d = StLoad;
        end
      end
`ifdef CONFIG_LOADER_CHECKSUM_EN
      StCheck: begin
        if (cfg_valid) begin
          if (cfg_data == csum_q) begin
            state_d  = StSettleFf;
            tmr_load = 1'b1;
          end else begin
            state_d = StError;
            err_d   = 1'b1;
            ff_en_d = 1'b0;
          end
        end
      end
`endif
      StSettleFf: begin
        if (tmr_done) begin
          ff_en_d  = 1'b1;
          state_d  = StSettleRdy;
          tmr_load = 1'b1;
        end
      end
      StSettleRdy: begin
        if (tmr_done) begin
          rdy_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone, StError: begin
        // Reconfiguration drops the fabric out of run mode on the same edge.
        if (start) begin
          state_d     = StLoad;
          frame_cnt_d = '0;
          ff_en_d     = 1'b0;
          rdy_d       = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
          err_d       = 1'b0;
          csum_d      = '0;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      frame_cnt_q  <= '0;
      configs_in_q <= '0;
      ff_en_q      <= 1'b0;
      rdy_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      frame_cnt_q  <= frame_cnt_d;
      configs_in_q <= configs_in_d;
      ff_en_q      <= ff_en_d;
      rdy_q        <= rdy_d;
    end
  end

`ifdef CONFIG_LOADER_CHECKSUM_EN
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
      err_q  <= 1'b0;
    end else begin
      csum_q <= csum_d;
      err_q  <= err_d;
    end
  end

  assign err       = err_q;
  assign cfg_ready = (state_q == StLoad) || (state_q == StCheck);
`else
  assign err       = 1'b0;
  assign cfg_ready = (state_q == StLoad);
`endif

  assign configs_en = (state_q == StWrite) ? (EnOne << frame_cnt_q) : '0;
  assign configs_in = configs_in_q;
  assign ff_en      = ff_en_q;
  assign rdy        = rdy_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = !(state_q inside {StIdle, StDone, StError});

endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader against a transaction-level load model.
// Honours CONFIG_LOADER_CHECKSUM_EN to exercise the trailer check.
module tb_config_loader;

  localparam int unsigned WordW     = 8;
  localparam int unsigned NumFrames = 4;
  localparam int unsigned Settle    = 3;
  localparam int unsigned CntW      = $clog2(NumFrames + 1);

  logic                 clock = 1'b0;
  logic                 rst, start, cfg_valid, cfg_ready;
  logic [WordW-1:0]     cfg_data, configs_in;
  logic [NumFrames-1:0] configs_en;
  logic                 ff_en, rdy, busy, err;
  logic [CntW-1:0]      frame_cnt;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [WordW-1:0]     words [NumFrames];
  logic [NumFrames-1:0] en_one = NumFrames'(1);
`ifdef CONFIG_LOADER_CHECKSUM_EN
  bit                   bad_trailer = 1'b0;
`endif

  always #5 clock = ~clock;

  config_loader #(
    .WORD_W        (WordW),
    .NUM_FRAMES    (NumFrames),
    .SETTLE_CYCLES (Settle)
  ) dut (
    .clock      (clock),
    .rst        (rst),
    .start      (start),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_data   (cfg_data),
    .configs_in (configs_in),
    .configs_en (configs_en),
    .ff_en      (ff_en),
    .rdy        (rdy),
    .busy       (busy),
    .frame_cnt  (frame_cnt),
    .err        (err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cfg_in"}, 64'(configs_in), 64'(0));
    check({tag, "_cfg_en"}, 64'(configs_en), 64'(0));
    check({tag, "_ff_en"}, 64'(ff_en), 64'(0));
    check({tag, "_rdy"}, 64'(rdy), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_frame_cnt"}, 64'(frame_cnt), 64'(0));
    check({tag, "_err"}, 64'(err), 64'(0));
    check({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(0));
  endtask

  // Model: each accepted word yields exactly one strobe on the following cycle,
  // in order; after the last frame, ff_en and rdy follow at fixed settle delays.
  task automatic run_load(input int vmode, input int gap_after, input int gap_len,
                          input int abort_after, input bit start_in_write,
                          input bit start_in_settle);
    int sent, strobes, gap, budget;
    bit pend;
    logic [NumFrames-1:0] exp_en;
    start = 1'b1;
    cfg_valid = 1'b0;
    tick();
    start = 1'b0;
    check("start_frame_cnt", 64'(frame_cnt), 64'(0));
    check("start_ff_en", 64'(ff_en), 64'(0));
    check("start_rdy", 64'(rdy), 64'(0));
    check("start_err", 64'(err), 64'(0));
    check("start_busy", 64'(busy), 64'(1));
    sent = 0; strobes = 0; gap = 0; budget = 0; pend = 1'b0;
    while (strobes < NumFrames) begin
      if (strobes == abort_after) return;
      if (budget++ > 500) begin
        check("load_timeout", 64'(strobes), 64'(NumFrames));
        return;
      end
      exp_en = pend ? (en_one << strobes) : '0;
      check("configs_en", 64'(configs_en), 64'(exp_en));
      check("frame_cnt", 64'(frame_cnt), 64'(strobes));
      check("cfg_ready", 64'(cfg_ready), 64'(!pend));
      check("busy_load", 64'(busy), 64'(1));
      if (pend) check("configs_in", 64'(configs_in), 64'(words[strobes]));
      start = start_in_write && pend && (strobes == 1);
      if (pend) begin
        // Junk offered while writing must never be consumed.
        cfg_valid = (vmode == 0) || ($urandom_range(0, 1) == 1);
        cfg_data  = ~words[strobes];
      end else if (sent == gap_after && gap < gap_len) begin
        cfg_valid = 1'b0;
        gap++;
      end else begin
        cfg_valid = (vmode == 0) || ($urandom_range(0, 2) != 0);
        cfg_data  = words[sent];
      end
      if (pend) begin
        pend = 1'b0;
        strobes++;
      end else if (cfg_valid) begin
        pend = 1'b1;
        sent++;
      end
      tick();
    end
    start = 1'b0;
`ifdef CONFIG_LOADER_CHECKSUM_EN
    begin
      logic [WordW-1:0] xsum;
      int wait_n;
      xsum = '0;
      for (int i = 0; i < int'(NumFrames); i++) xsum ^= words[i];
      wait_n = $urandom_range(0, 2);
      for (int i = 0; i < wait_n; i++) begin
        cfg_valid = 1'b0;
        check("check_ready_wait", 64'(cfg_ready), 64'(1));
        check("check_en_wait", 64'(configs_en), 64'(0));
        tick();
      end
      check("check_ready", 64'(cfg_ready), 64'(1));
      cfg_valid = 1'b1;
      cfg_data  = bad_trailer ? (xsum ^ WordW'(1)) : xsum;
      tick();
      cfg_valid = 1'b0;
      if (bad_trailer) begin
        check("bad_err", 64'(err), 64'(1));
        check("bad_ff_en", 64'(ff_en), 64'(0));
        check("bad_rdy", 64'(rdy), 64'(0));
        check("bad_busy", 64'(busy), 64'(0));
        check("bad_frame_cnt", 64'(frame_cnt), 64'(NumFrames));
        return;
      end
    end
`endif
    for (int k = 1; k <= int'(2 * Settle + 1); k++) begin
      check("settle_ff_en", 64'(ff_en), 64'(k >= int'(Settle + 1)));
      check("settle_rdy", 64'(rdy), 64'(k >= int'(2 * Settle + 1)));
      check("settle_busy", 64'(busy), 64'(k < int'(2 * Settle + 1)));
      check("settle_en", 64'(configs_en), 64'(0));
      check("settle_ready", 64'(cfg_ready), 64'(0));
      check("settle_frame_cnt", 64'(frame_cnt), 64'(NumFrames));
      check("settle_err", 64'(err), 64'(0));
      start     = start_in_settle && (k == 1);
      cfg_valid = ($urandom_range(0, 1) == 1);
      cfg_data  = WordW'($urandom);
      tick();
    end
    start = 1'b0;
    cfg_valid = 1'b0;
    check("done_ff_en", 64'(ff_en), 64'(1));
    check("done_rdy", 64'(rdy), 64'(1));
    check("done_busy", 64'(busy), 64'(0));
  endtask

  task automatic set_directed_words();
    words[0] = 8'h11;
    words[1] = 8'h22;
    words[2] = 8'h33;
    words[3] = 8'h44;
  endtask

  task automatic set_random_words();
    for (int i = 0; i < int'(NumFrames); i++) words[i] = WordW'($urandom);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    cfg_valid = 1'b0;
    cfg_data = '0;
    #12;
    check_reset_outputs("reset");
    tick();
    rst = 1'b0;
    tick();
    check_reset_outputs("idle");

    // Directed load with valid held high.
    set_directed_words();
    run_load(0, -1, 0, -1, 1'b0, 1'b0);

    // Start ignored in WRITE and SETTLE_FF; start in DONE reloads.
    set_random_words();
    run_load(1, -1, 0, -1, 1'b1, 1'b1);

    // Five-cycle valid gap between words 2 and 3.
    set_directed_words();
    run_load(0, 2, 5, -1, 1'b0, 1'b0);

    // Reset after two frames, then a fresh full load.
    set_random_words();
    run_load(1, -1, 0, 2, 1'b0, 1'b0);
    cfg_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("midload_rst");
    tick();
    check_reset_outputs("midload_rst_hold");
    rst = 1'b0;
    tick();
    set_random_words();
    run_load(0, -1, 0, -1, 1'b0, 1'b0);

`ifdef CONFIG_LOADER_CHECKSUM_EN
    set_directed_words();
    bad_trailer = 1'b1;
    run_load(0, -1, 0, -1, 1'b0, 1'b0);
    bad_trailer = 1'b0;
    run_load(0, -1, 0, -1, 1'b0, 1'b0);
`endif

    for (int it = 0; it < 8; it++) begin
      set_random_words();
      run_load(1, $urandom_range(0, 3), $urandom_range(0, 4), -1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
